// File: rtl/dmi_dtm_master.sv
// dmi_dtm_master: DTM-side DMI requester that turns DR updates into dmi_req transactions
// and keeps the capture registers and sticky op status.
package dm;
    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2,
        DTM_RSVD  = 2'd3
    } dtm_op_e;
    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

module dmi_dtm_master #(
    parameter int unsigned RespTimeout  = 0,
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         update_i,
    input  logic [1:0]   update_op_i,
    input  logic [6:0]   update_addr_i,
    input  logic [31:0]  update_data_i,
    input  logic         capture_i,
    input  logic         dmireset_i,
    input  logic         dmihardreset_i,
    output logic [6:0]   cap_addr_o,
    output logic [31:0]  cap_data_o,
    output logic [1:0]   cap_op_o,
    output logic         dmi_req_valid_o,
    input  logic         dmi_req_ready_i,
    output dm::dmi_req_t dmi_req_o,
    input  logic         dmi_resp_valid_i,
    output logic         dmi_resp_ready_o,
    input  dm::dmi_resp_t dmi_resp_i,
    output logic         busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    state_e                  state_q, state_d;
    dm::dmi_req_t            req_q, req_d;
    logic [1:0]              sticky_q, sticky_d, cap_op_q, cap_op_d;
    logic [31:0]             result_q, result_d, cap_data_q, cap_data_d;
    logic [6:0]              cap_addr_q, cap_addr_d;
    logic [TimeoutWidth-1:0] cnt_q, cnt_d, cnt_inc;
    logic                    busy, timeout, start;

    assign busy    = state_q != IDLE;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign timeout = (RespTimeout != 0) && (cnt_inc >= TimeoutWidth'(RespTimeout));
    // dmireset in the same cycle as an update clears sticky early enough to let it through
    assign start   = update_i && !dmihardreset_i && (sticky_q == 2'd0 || dmireset_i) &&
                     (update_op_i == dm::DTM_READ || update_op_i == dm::DTM_WRITE);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        sticky_d   = sticky_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_op_d   = cap_op_q;
        unique case (state_q)
            IDLE: if (start) begin
                req_d   = '{addr: update_addr_i, op: dm::dtm_op_e'(update_op_i), data: update_data_i};
                state_d = REQ;
            end
            REQ: if (dmihardreset_i) begin
                state_d = IDLE;
            end else if (dmi_req_ready_i) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (dmihardreset_i) begin
                    state_d = DRAIN;
                end else if (dmi_resp_valid_i) begin
                    state_d  = IDLE;
                    result_d = req_q.op == dm::DTM_READ ? dmi_resp_i.data : result_q;
                    sticky_d = (dmi_resp_i.resp != 2'd0 && sticky_q != 2'd3) ? 2'd2 : sticky_q;
                end else if (timeout) begin
                    state_d  = DRAIN;
                    sticky_d = sticky_q == 2'd3 ? 2'd3 : 2'd2;
                end
            end
            DRAIN: if (dmi_resp_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (capture_i) begin
            cap_addr_d = req_q.addr;
            cap_data_d = result_q;
            cap_op_d   = sticky_q != 2'd0 ? sticky_q : busy ? 2'd3 : 2'd0;
        end
        if (busy && (update_i || (capture_i && sticky_q == 2'd0))) sticky_d = 2'd3;
        if (dmireset_i || dmihardreset_i) sticky_d = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            sticky_q   <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_op_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            sticky_q   <= sticky_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_op_q   <= cap_op_d;
        end
    end

    assign dmi_req_valid_o  = state_q == REQ;
    assign dmi_resp_ready_o = state_q == WAIT || state_q == DRAIN;
    assign dmi_req_o        = req_q;
    assign busy_o           = busy;
    assign cap_addr_o       = cap_addr_q;
    assign cap_data_o       = cap_data_q;
    assign cap_op_o         = cap_op_q;
endmodule

// File: doc/dmi_dtm_master.md
# dmi_dtm_master

DTM-side initiator of the Debug Module Interface. It converts Debug Transport Module register events into `dmi_req` transactions, collects the matching `dmi_resp`, and keeps the DTM-visible result registers and sticky op status. It sits between the JTAG TAP DR logic (already synchronised into `clk_i`) and the DMI slave port of the debug module's CSR block. It is the requester for the valid/ready request and response channels that the CSR block answers.

## Interface

- `RespTimeout`, default 0: maximum number of cycles spent in WAIT before the op is declared failed. 0 disables the timeout.
- `TimeoutWidth`, default 16: width of the timeout counter. `RespTimeout` must be less than 2^TimeoutWidth.

Ports (one clock; reset is synchronous and active-high):

- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `update_i`  in  1  one-cycle pulse: DR update of the DMI register
- `update_op_i`  in  2  op field (`dm::dtm_op_e`: 0 NOP, 1 READ, 2 WRITE, 3 reserved→NOP)
- `update_addr_i`  in  7  DMI address
- `update_data_i`  in  32  write data
- `capture_i`  in  1  one-cycle pulse: DR capture
- `dmireset_i`  in  1  pulse: clear sticky status
- `dmihardreset_i`  in  1  pulse: abort the in-flight op and clear sticky status
- `cap_addr_o`  out  7  address value for the shift register
- `cap_data_o`  out  32  data value for the shift register
- `cap_op_o`  out  2  status: 0 success, 2 failed, 3 busy
- `dmi_req_valid_o`  out  1  request valid
- `dmi_req_ready_i`  in  1  request ready
- `dmi_req_o`  out  `dm::dmi_req_t`  request {addr, op, data}
- `dmi_resp_valid_i`  in  1  response valid
- `dmi_resp_ready_o`  out  1  response ready
- `dmi_resp_i`  in  `dm::dmi_resp_t`  response {data, resp}
- `busy_o`  out  1  high whenever the state is not IDLE

## Operation

States:
- IDLE
- REQ: `dmi_req_valid_o`=1
- WAIT: `dmi_resp_ready_o`=1
- DRAIN: `dmi_resp_ready_o`=1, the response is discarded

Update handling:
- `update_i` in IDLE, sticky=0, op READ/WRITE: latch addr/op/data into `dmi_req_o`, go to REQ.
- `update_i` in IDLE with NOP or reserved op: no transaction; nothing latched.
- `update_i` while sticky≠0: ignored.
- `update_i` while not IDLE: ignored and sticky←3.

Transitions:
- REQ→WAIT on `dmi_req_valid_o & dmi_req_ready_i`. `dmi_req_o` stays stable while valid.
- WAIT→IDLE on `dmi_resp_valid_i & dmi_resp_ready_o`. If the op was READ, result data←`dmi_resp_i.data`. If `resp`≠0, sticky←2 (sticky 3 takes priority and is not downgraded).
- Timeout in WAIT: the counter clears on entry to WAIT and increments each WAIT cycle. When `RespTimeout`≠0 and the count reaches `RespTimeout`: sticky←2, go to DRAIN.
- DRAIN→IDLE on a response handshake.

Capture (`capture_i`) latches the capture outputs:
- `cap_addr_o`←last issued addr.
- `cap_data_o`←result data.
- `cap_op_o`←sticky if sticky≠0; else 3 if state≠IDLE (and sticky←3); else 0.

Resets and simultaneous events:
- `dmireset_i`: sticky←0; the state is untouched.
- `dmihardreset_i`: sticky←0. REQ→IDLE with the request dropped. WAIT→DRAIN. IDLE and DRAIN are unchanged.
- Same cycle, priority order: `rst_i` > `dmihardreset_i` > `dmireset_i` > response completion > `update_i`/`capture_i`.
- `dmireset_i` with `update_i` in IDLE: the update is accepted.
- `capture_i` in the same cycle as WAIT→IDLE: sees WAIT, so `cap_op_o`=3 and sticky←3.
- `capture_i` with `update_i`: capture uses pre-update values.

## Timing

- Reset values: all outputs are 0, the state is IDLE, sticky=0, and the result/addr registers are 0.
- The update is registered: `dmi_req_valid_o` rises the cycle after `update_i`.
- Ready may already be high in that cycle: with ready high, REQ lasts exactly 1 cycle, and `dmi_resp_ready_o` rises the cycle after the request handshake.
- Response handshake at cycle N: state IDLE and `busy_o`=0 at N+1; result data is visible to a capture from N+1.
- Minimum update-to-IDLE: 3 cycles, with ready high and the response arriving in the first WAIT cycle.
- The capture outputs update the cycle after `capture_i` and otherwise hold.
- The timeout counter saturates; it never wraps.

## Test plan

1. WRITE, zero wait: update op=2, addr=0x10, data=0x1 with `dmi_req_ready_i`=1 and an immediate response, resp=0 → one request {0x10, 2, 0x1}; a later capture gives op=0, addr=0x10.
2. READ with backpressure: hold ready low 5 cycles, then send resp data=0xDEADBEEF, resp=0 → valid held stable for 6 cycles; a capture gives data=0xDEADBEEF, op=0.
3. Busy: capture during WAIT → `cap_op_o`=3. A following update is ignored, no new request is issued, and a capture after completion still gives 3.
4. `dmireset_i` clears sticky → the next capture gives 0 and the next update is issued.
5. Failed response: resp=2 → capture gives op=2; the next update produces no request until `dmireset_i`.
6. `RespTimeout`=4 with no response → after 4 WAIT cycles: DRAIN, capture gives op=2. A late response is accepted and discarded, then IDLE. Separately, `dmihardreset_i` in REQ → valid drops the next cycle, sticky=0.
